// File: rtl/alu_pkg.sv
// Definitions shared by the execute-stage ALU and the iterative divider.
// The state encoding and the default operand width live here.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the result if it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] trial;

  // The remainder is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the trial result's top bit is its sign.
  assign r_shift = {r_i[WIDTH-1:0], q_msb_i};
  assign trial   = r_shift - {1'b0, d_i};

  always_comb begin
    if (!trial[WIDTH]) begin
      r_o     = trial;
      q_bit_o = 1'b1;
    end else begin
      r_o     = r_shift;
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div_sub_seq.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU: one restoring step per clock,
// with sign fix-up and divide-by-zero handling before the results are published.
module div_sub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic             sign_q, sign_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_r;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[WIDTH-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .q_bit_o (step_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      sign_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      sign_q  <= sign_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    sign_d  = sign_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          sign_d  = sign;
          neg_q_d = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_d = sign & dividend[WIDTH-1];
          state_d = PREP;
        end
      end
      PREP: begin
        if (sign_q && q_q[WIDTH-1]) q_d = -q_q;
        if (sign_q && d_q[WIDTH-1]) d_d = -d_q;
        r_d     = '0;
        cnt_d   = '0;
        state_d = (d_q == '0) ? FIX : ITER;
      end
      ITER: begin
        q_d   = {q_q[WIDTH-2:0], step_bit};
        r_d   = step_r;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (d_q == '0) begin
          // Q still holds the dividend magnitude here, so re-applying the
          // dividend sign restores the original operand.
          quot_d = '1;
          rem_d  = neg_r_q ? -q_q : q_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = neg_q_q ? -q_q : q_q;
          rem_d  = neg_r_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
          dz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule
